zigzag_decryption_nrail: RTL

//   Rail-fence (zigzag) decryptor for any key 2..MAX_KEY. Successor to the fixed key-2/3 zigzag decryptor.

---
 rtl/zigzag_decryption_nrail.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/zigzag_decryption_nrail.sv
// -----------------------------------------------------------------------------
// zigzag_decryption_nrail
//
// Rail-fence (zigzag) decryptor for any rail count from 2 to MAX_KEY.
// Encrypted characters are buffered until the in-band start token arrives.
// The block then makes three passes over the message:
//   COUNT - walks the zigzag once to count how many characters land on each rail
//   SUM   - turns those counts into the start offset of each rail in the buffer
//   OUT   - walks the zigzag again, reading the next character of the current rail
// Keys outside 2..MAX_KEY decode as a single rail, which is plain passthrough.
//
// Ports
//   clk       system clock
//   rst       synchronous reset, active-high; aborts any operation in progress
//   data_i    encrypted character or start token
//   valid_i   data_i qualifier
//   key       rail count, sampled only on the token cycle
//   busy      high while a message is being decrypted; input is ignored meanwhile
//   data_o    decrypted character
//   valid_o   data_o qualifier
//   overflow  sticky flag: a character was dropped because the buffer was full
// -----------------------------------------------------------------------------
module zigzag_decryption_nrail #(
   parameter int                  D_WIDTH                = 8,
   parameter int                  KEY_WIDTH              = 16,
   parameter int                  MAX_NOF_CHARS          = 50,
   parameter int                  MAX_KEY                = 8,
   parameter logic [D_WIDTH-1:0]  START_DECRYPTION_TOKEN = 8'hFA
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [D_WIDTH-1:0]   data_i,
   input  logic                 valid_i,
   input  logic [KEY_WIDTH-1:0] key,
   output logic                 busy,
   output logic [D_WIDTH-1:0]   data_o,
   output logic                 valid_o,
   output logic                 overflow
);

   localparam int CW = $clog2(MAX_NOF_CHARS + 1);
   localparam int AW = $clog2(MAX_NOF_CHARS);
   localparam int RW = $clog2(MAX_KEY);
   localparam int KW = $clog2(MAX_KEY + 1);

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      SUM,
      OUT
   } state_t;

   state_t              state_q;
   state_t              state_d;

   logic [D_WIDTH-1:0]  mem [MAX_NOF_CHARS];
   logic [CW-1:0]       len_q [MAX_KEY];
   logic [CW-1:0]       ptr_q [MAX_KEY];

   logic [CW-1:0]       n_q;
   logic [CW-1:0]       pos_q;
   logic [CW-1:0]       acc_q;
   logic [KW-1:0]       keff_q;
   logic [RW-1:0]       r_q;
   logic [RW-1:0]       r_d;
   logic [RW-1:0]       idx_q;
   logic                dir_q;
   logic                dir_d;

   // Next state plus the bouncing rail walk shared by COUNT and OUT.
   // dir 0 means walking down towards rail keff-1, dir 1 walking back up to 0.
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      dir_d   = dir_q;

      if (keff_q == KW'(1)) begin
         r_d   = '0;
         dir_d = 1'b0;
      end else if (!dir_q) begin
         if (KW'(r_q) == keff_q - KW'(1)) begin
            r_d   = r_q - RW'(1);
            dir_d = 1'b1;
         end else begin
            r_d = r_q + RW'(1);
         end
      end else begin
         if (r_q == '0) begin
            r_d   = r_q + RW'(1);
            dir_d = 1'b0;
         end else begin
            r_d = r_q - RW'(1);
         end
      end

      case (state_q)
         IDLE: begin
            if (valid_i && (data_i == START_DECRYPTION_TOKEN) && (n_q != '0)) begin
               state_d = COUNT;
            end
         end
         COUNT: begin
            if (pos_q == n_q - CW'(1)) begin
               state_d = SUM;
            end
         end
         SUM: begin
            if (KW'(idx_q) == keff_q - KW'(1)) begin
               state_d = OUT;
            end
         end
         OUT: begin
            // The cycle after the last character is spent clearing the outputs.
            if (pos_q == n_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register and datapath; every output is driven from here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         busy     <= 1'b0;
         valid_o  <= 1'b0;
         data_o   <= '0;
         overflow <= 1'b0;
         n_q      <= '0;
         pos_q    <= '0;
         acc_q    <= '0;
         keff_q   <= KW'(1);
         r_q      <= '0;
         idx_q    <= '0;
         dir_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (valid_i) begin
                  if (data_i == START_DECRYPTION_TOKEN) begin
                     // An empty buffer makes the token a no-op.
                     if (n_q != '0) begin
                        keff_q <= ((key >= KEY_WIDTH'(2)) && (key <= KEY_WIDTH'(MAX_KEY))) ?
                                  KW'(key) : KW'(1);
                        for (int i = 0; i < MAX_KEY; i++) begin
                           len_q[i] <= '0;
                        end
                        busy  <= 1'b1;
                        r_q   <= '0;
                        dir_q <= 1'b0;
                        pos_q <= '0;
                     end
                  end else if (n_q < CW'(MAX_NOF_CHARS)) begin
                     mem[n_q[AW-1:0]] <= data_i;
                     n_q              <= n_q + CW'(1);
                  end else begin
                     overflow <= 1'b1;
                  end
               end
            end

            COUNT: begin
               len_q[r_q] <= len_q[r_q] + CW'(1);
               r_q        <= r_d;
               dir_q      <= dir_d;
               pos_q      <= pos_q + CW'(1);
               if (pos_q == n_q - CW'(1)) begin
                  pos_q <= '0;
                  idx_q <= '0;
                  acc_q <= '0;
                  r_q   <= '0;
                  dir_q <= 1'b0;
               end
            end

            SUM: begin
               // Exclusive prefix sum: each rail starts where the previous ones end.
               ptr_q[idx_q] <= acc_q;
               acc_q        <= acc_q + len_q[idx_q];
               idx_q        <= idx_q + RW'(1);
            end

            OUT: begin
               if (pos_q < n_q) begin
                  data_o     <= mem[ptr_q[r_q][AW-1:0]];
                  valid_o    <= 1'b1;
                  ptr_q[r_q] <= ptr_q[r_q] + CW'(1);
                  r_q        <= r_d;
                  dir_q      <= dir_d;
                  pos_q      <= pos_q + CW'(1);
               end else begin
                  valid_o  <= 1'b0;
                  data_o   <= '0;
                  busy     <= 1'b0;
                  n_q      <= '0;
                  overflow <= 1'b0;
               end
            end

            default: ;
         endcase
      end
   end

endmodule
